// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the MEM-stage data-memory responder:
//                RV32I funct3 access codes, responder state encoding and the
//                latency counter width.
//  Contents    : F3_* funct3 constants, state_t, CNT_W
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   // RV32I load/store size and sign encodings (funct3)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Width of the latency down-counter; LATENCY-1 must fit (LATENCY <= 15)
   localparam int CNT_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational RV32I lane logic shared by store merge and
//                load extract.
//  Ports       : funct3        in  access size/sign code
//                addr_lo[1:0]  in  byte offset within the word
//                word_in[31:0] in  current memory word (load source)
//                wdata[31:0]   in  right-aligned store data
//                byte_en[3:0]  out lanes touched by a store of this size
//                aligned_wdata out store data replicated onto every lane
//                load_ext      out selected lane(s), sign/zero extended
//                misaligned    out half on odd byte / word off word boundary
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   output logic [3:0]  byte_en,
   output logic [31:0] aligned_wdata,
   output logic [31:0] load_ext,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word_in[8*addr_lo +: 8];
   assign half_sel = word_in[16*addr_lo[1] +: 16];

   always_comb begin
      byte_en       = 4'b0000;
      aligned_wdata = wdata;
      load_ext      = 32'h0;
      misaligned    = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            byte_en       = 4'b0001 << addr_lo;
            // Replicating onto every lane lets byte_en alone pick the target
            aligned_wdata = {4{wdata[7:0]}};
            load_ext      = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
         end
         F3_H, F3_HU: begin
            byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
            aligned_wdata = {2{wdata[15:0]}};
            load_ext      = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0, half_sel};
            misaligned    = addr_lo[0];
         end
         F3_W: begin
            byte_en       = 4'b1111;
            load_ext      = word_in;
            misaligned    = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : MEM-stage data-memory responder. Accepts one load/store at a
//                time, holds it for LATENCY cycles, then performs the access
//                and returns a single-cycle response.
//  Ports       : clk, reset            clock, synchronous active-high reset
//                req_valid/req_ready   request handshake (ready only in IDLE)
//                req_write, req_funct3 store flag and RV32I size/sign code
//                req_addr, req_wdata   byte address, right-aligned store data
//                rsp_valid             one-cycle completion pulse
//                rsp_rdata, rsp_err    load data / error, held until next rsp
//                busy                  high whenever a request is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int               AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             write_q;
   logic [2:0]       funct3_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic [31:0]      mem [DEPTH_WORDS];

   logic             accept, complete, in_range, bad_funct3, err, store_en;
   logic [31:0]      word_in, aligned_wdata, load_ext;
   logic [3:0]       byte_en;
   logic             misaligned;

   assign accept   = (state == ST_IDLE) && req_valid;
   assign complete = (state == ST_BUSY) && (cnt == '0);
   assign in_range = (addr_q[31:2] < DEPTH_LIM);
   // Loads accept B/H/W/BU/HU; stores accept only B/H/W
   assign bad_funct3 = write_q ? (funct3_q > F3_W)
                               : ((funct3_q == 3'b011) || (funct3_q == 3'b110) ||
                                  (funct3_q == 3'b111));
   assign err      = misaligned || !in_range || bad_funct3;
   assign store_en = complete && write_q && !err;
   assign word_in  = in_range ? mem[addr_q[AW+1:2]] : 32'h0;

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state == ST_BUSY);

   mem_lane_align u_align (
      .funct3        (funct3_q),
      .addr_lo       (addr_q[1:0]),
      .word_in       (word_in),
      .wdata         (wdata_q),
      .byte_en       (byte_en),
      .aligned_wdata (aligned_wdata),
      .load_ext      (load_ext),
      .misaligned    (misaligned)
   );

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (req_valid) state_next = ST_BUSY;
         ST_BUSY: if (cnt == '0) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         write_q   <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
      end else begin
         state     <= state_next;
         rsp_valid <= 1'b0;
         if (accept) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            cnt      <= CNT_LOAD;
         end else if (state == ST_BUSY) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               rsp_valid <= 1'b1;
               rsp_err   <= err;
               rsp_rdata <= (err || write_q) ? 32'h0 : load_ext;
            end
         end
      end
   end

   // Storage is deliberately not cleared by reset; reset only blocks the
   // completing write of a request that is being dropped.
   always_ff @(posedge clk) begin
      if (!reset && store_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= aligned_wdata[8*i +: 8];
         end
      end
   end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder
//                (LATENCY=2, DEPTH_WORDS=256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Issue one request when ready, then wait (bounded) for its response.
   // lat = edges from accept to the edge that raised rsp_valid, -1 on timeout.
   task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic er, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
      req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = -1; rd = 32'hxxxxxxxx; er = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         if (lat < 0) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      n_checks++; if ({rsp_err, rsp_rdata} !== 33'h0) begin n_fail++; $display("FAIL reset_rsp got=%b/%h exp=0/00000000", rsp_err, rsp_rdata); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT); end
      n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL sw_rsp got=%b/%h exp=0/00000000", er, rd); end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL lw_latency got=%0d exp=%0d", lat, LAT); end
      n_checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL lw_rsp got=%b/%h exp=0/deadbeef", er, rd); end
      // Pulse must be a single cycle, data must hold afterwards
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse got=%b exp=0", rsp_valid); end
      n_checks++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rsp_hold got=%h exp=deadbeef", rsp_rdata); end
   endtask

   task automatic test_byte();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b000, 32'h11, 32'h00000080, rd, er, lat);
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_err got=%b exp=0", er); end
      do_req(1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb got=%h exp=ffffff80", rd); end
      do_req(1'b0, 3'b100, 32'h11, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu got=%h exp=00000080", rd); end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'hDEAD80EF) begin n_fail++; $display("FAIL lw_after_sb got=%h exp=dead80ef", rd); end
      do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL lb_lane3 got=%h exp=ffffffde", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b001, 32'h13, 32'h0000FFFF, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL sh_misaligned got=%b/%h exp=1/00000000", er, rd); end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b0, 32'hDEAD80EF}) begin n_fail++; $display("FAIL lw_unchanged got=%b/%h exp=0/dead80ef", er, rd); end
      do_req(1'b0, 3'b010, 32'h402, 32'h0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL lw_0x402 got=%b/%h exp=1/00000000", er, rd); end
      do_req(1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat);
      n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw_range_edge got=%b exp=1", er); end
      do_req(1'b1, 3'b010, 32'h3FC, 32'h0BADF00D, rd, er, lat);
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_last_word got=%b exp=0", er); end
      do_req(1'b0, 3'b010, 32'h3FC, 32'h0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b0, 32'h0BADF00D}) begin n_fail++; $display("FAIL lw_last_word got=%b/%h exp=0/0badf00d", er, rd); end
      do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL load_f3_011 got=%b/%h exp=1/00000000", er, rd); end
      do_req(1'b1, 3'b100, 32'h10, 32'h0, rd, er, lat);
      n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL store_f3_100 got=%b exp=1", er); end
      do_req(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat);
      n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw_misaligned got=%b exp=1", er); end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'hDEAD80EF) begin n_fail++; $display("FAIL lw_after_bad_stores got=%h exp=dead80ef", rd); end
   endtask

   task automatic test_half();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h20, 32'h11112222, rd, er, lat);
      do_req(1'b1, 3'b001, 32'h22, 32'h00008001, rd, er, lat);
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sh_err got=%b exp=0", er); end
      do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh got=%h exp=ffff8001", rd); end
      do_req(1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu got=%h exp=00008001", rd); end
      do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      n_checks++; if (rd !== 32'h80012222) begin n_fail++; $display("FAIL lw_after_sh got=%h exp=80012222", rd); end
   endtask

   // Two requests with req_valid held high; the second request's fields are
   // presented while the first is BUSY and must not disturb it.
   task automatic test_back_to_back();
      int first_rsp = -1, second_rsp = -1;
      @(negedge clk);
      req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hA5A5A5A5;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_write = 1'b0; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (rsp_valid && first_rsp < 0) first_rsp = n;
         else if (rsp_valid) second_rsp = n;
         if (n == 1) begin
            n_checks++; if ({busy, req_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_busy_cycle1 got=%b%b exp=10", busy, req_ready); end
         end
         if (n == 2) begin
            n_checks++; if ({busy, req_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_ready_at_rsp got=%b%b exp=01", busy, req_ready); end
         end
         if (n == 3) begin
            req_valid = 1'b0;
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
         end
         if (n == 5) begin
            n_checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL b2b_load got=%b/%h exp=0/a5a5a5a5", rsp_err, rsp_rdata); end
         end
      end
      req_valid = 1'b0;
      n_checks++; if (first_rsp !== 2) begin n_fail++; $display("FAIL b2b_first_rsp got=%0d exp=2", first_rsp); end
      n_checks++; if (second_rsp !== 5) begin n_fail++; $display("FAIL b2b_second_rsp got=%0d exp=5", second_rsp); end
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] rd; logic er; int lat;
      int seen = 0;
      do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, rd, er, lat);
      @(negedge clk);
      req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int n = 0; n < 2; n++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
         if (n == 0) begin
            n_checks++; if ({req_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL post_reset_idle got=%b%b exp=10", req_ready, busy); end
         end
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL dropped_no_rsp got=%0d exp=0", seen); end
      do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
      n_checks++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) begin n_fail++; $display("FAIL dropped_no_write got=%b/%h exp=0/cafef00d", er, rd); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_errors();
      test_half();
      test_back_to_back();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_data_mem_responder
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the MEM-stage data-memory interface: accepts one load/store request at a time from the MEM stage, holds it for a programmable latency, then performs the access and returns one response.
- Implements RV32I byte/halfword/word lanes (funct3-coded), load sign/zero extension, and misalignment/range/funct3 error detection.
- Drives busy so the pipeline stalls MEM until the response arrives.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the storage array; byte address range is 0 to 4*DEPTH_WORDS-1.
- LATENCY, 2, cycles from the request-accept edge to the edge that asserts rsp_valid; legal range 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I access size and sign (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle pulse: access completed.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected; valid with rsp_valid.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, BUSY.
  - IDLE: req_ready=1. On req_valid, capture write/funct3/addr/wdata, load cnt<=LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. If cnt!=0, cnt<=cnt-1. If cnt==0, perform the access, set rsp_valid<=1, go to IDLE.
- Timing: a request accepted at edge E gives rsp_valid high for exactly the one cycle following edge E+LATENCY.
  - rsp_valid defaults to 0 on every other edge.
  - req_ready is high again in the same cycle rsp_valid is high, so back-to-back throughput is one request per LATENCY+1 cycles.
- rsp_rdata and rsp_err hold their values until the next response; they are qualified only by rsp_valid.
- Error conditions: rsp_err=1, no memory change, rsp_rdata=0.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=00.
  - addr[31:2] >= DEPTH_WORDS.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 other than {000, 001, 010}.
- Stores (write enabled only on the completing edge):
  - SB writes req_wdata[7:0] to byte lane addr[1:0].
  - SH writes req_wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes the whole word.
  - Other lanes are preserved.
- Loads: select the lane(s) by addr[1:0]. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW returns the word unchanged.
- Storage: DEPTH_WORDS x 32 array indexed by addr[31:2]. Contents are not cleared by reset.
- Reset (including mid-BUSY):
  - state<=IDLE, cnt<=0, rsp_valid<=0, rsp_rdata<=0, rsp_err<=0.
  - The in-flight request is dropped with no memory write and no response.
  - req_ready=1 and busy=0 in the first cycle after reset.
- req_valid during BUSY is ignored; the requester holds it. Request inputs are sampled only at the accept edge; changes while BUSY have no effect.

Decomposition:
- Shared package (mem_pkg):
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding IDLE=0, BUSY=1.
  - LATENCY counter width constant (4 bits).
- Sub-module mem_lane_align, combinational:
  - Inputs funct3, addr[1:0], word_in, wdata.
  - Outputs byte_en[3:0], aligned_wdata[31:0], load_ext[31:0], misaligned.
  - Reused by the responder for both the store merge and the load extract.

Test Plan:
- LATENCY=2. SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> each rsp_valid exactly 2 cycles after accept; LW rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store and extending loads:
  - Prior word 0xDEADBEEF at 0x10, SB addr=0x11 wdata=0x00000080.
  - LB 0x11 -> 0xFFFFFF80.
  - LBU 0x11 -> 0x00000080.
  - LW 0x10 -> 0xDEAD80EF.
- Misaligned and out-of-range:
  - SH addr=0x13 -> rsp_err=1, LW 0x10 unchanged.
  - LW addr=0x402 with DEPTH_WORDS=256 -> rsp_err=1, rsp_rdata=0.
- Halfword loads: SH addr=0x22 wdata=0x00008001, then LH 0x22 -> 0xFFFF8001, LHU 0x22 -> 0x00008001.
- Backpressure: assert req_valid continuously with two requests -> second accepted only when req_ready returns; busy high for LATENCY cycles per request; req_valid in BUSY is not accepted.
- Reset mid-BUSY: accept SW 0x30 = 0x12345678, assert reset one cycle later -> no rsp_valid; subsequent LW 0x30 returns the prior contents, not 0x12345678.
